multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the 5-bit-opcode CPU datapath.
- Sequences fetch, decode, execute, memory and writeback for each instruction from the opcode field held in the IR.
- Drives PC, IR, register-file, ALU and memory enables.
- Handles variable-latency mult/div via a start/done handshake and memory via a req/ready handshake.

---
 rtl/multicycle_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/exec/mem/wb control FSM for the 5-bit-opcode datapath; HALT trap built only with `ILLEGAL_TRAP_EN`.
// 3-5 cycles per instruction plus stalls; mem_req is held until mem_ready, EXEC waits on md_done up to MD_TIMEOUT cycles.
module multicycle_ctrl #(
  parameter int CNT_W      = 16,
  parameter int MD_TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       opcode_i,
  input  logic             cmp_zero_i,
  input  logic             cmp_gt_i,
  input  logic             md_done_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             addr_sel_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic [1:0]       pc_src_o,
  output logic             alu_src_imm_o,
  output logic             alu_start_o,
  output logic             reg_write_o,
  output logic             wb_sel_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] retired_o,
  output logic             err_o,
  output logic             illegal_o
);

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [2:0] HALT   = 3'd5;
`endif

  localparam int MD_CW = $clog2(MD_TIMEOUT + 1);

  logic [2:0]       state_q, state_d;
  logic [MD_CW-1:0] md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] retired_q;
  logic             err_q;
  logic             retire, err_set, ill_set;
  logic             legal, is_md, is_lw, is_sw, is_j, is_jr, br_taken;

  always_comb begin
    legal = 1'b0;
    case (opcode_i)
      5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
      5'h09, 5'h0A, 5'h0C, 5'h0D, 5'h0E, 5'h0F,
      5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17: legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

  assign is_md = !opcode_i[4] && (opcode_i[2:1] == 2'b11);
  assign is_lw = (opcode_i == 5'h12);
  assign is_sw = (opcode_i == 5'h13);
  assign is_jr = (opcode_i == 5'h16);
  assign is_j  = (opcode_i == 5'h17);
  assign br_taken = ((opcode_i == 5'h14) &&  cmp_zero_i) ||
                    ((opcode_i == 5'h15) && !cmp_zero_i) ||
                    ((opcode_i == 5'h10) &&  cmp_gt_i);

  // Enables are qualified by rst_n so they fall the instant reset asserts, not at the next edge.
  always_comb begin
    state_d       = state_q;
    md_cnt_d      = '0;
    retire        = 1'b0;
    err_set       = 1'b0;
    ill_set       = 1'b0;
    mem_req_o     = 1'b0;
    mem_we_o      = 1'b0;
    addr_sel_o    = 1'b0;
    ir_write_o    = 1'b0;
    pc_write_o    = 1'b0;
    pc_src_o      = 2'b00;
    alu_src_imm_o = 1'b0;
    alu_start_o   = 1'b0;
    reg_write_o   = 1'b0;
    wb_sel_o      = 1'b0;
    if (rst_n) begin
      case (state_q)
        FETCH: begin
          mem_req_o = 1'b1;
          if (mem_ready_i) begin
            ir_write_o = 1'b1;
            pc_write_o = 1'b1;
            state_d    = DECODE;
          end
        end
        DECODE: begin
          if (legal) begin
            state_d = EXEC;
          end else begin
`ifdef ILLEGAL_TRAP_EN
            ill_set = 1'b1;
            state_d = HALT;
`else
            retire  = 1'b1;
            state_d = FETCH;
`endif
          end
        end
        EXEC: begin
          alu_src_imm_o = opcode_i[3] | is_lw | is_sw;
          if (is_md) begin
            alu_start_o = (md_cnt_q == '0);
            md_cnt_d    = md_cnt_q + MD_CW'(1);
            if (md_done_i) begin
              md_cnt_d = '0;
              state_d  = WB;
            end else if (md_cnt_q == MD_CW'(MD_TIMEOUT - 1)) begin
              md_cnt_d = '0;
              err_set  = 1'b1;
              state_d  = FETCH;
            end
          end else if (opcode_i == 5'h10 || opcode_i == 5'h14 || opcode_i == 5'h15) begin
            pc_write_o = br_taken;
            pc_src_o   = br_taken ? 2'b01 : 2'b00;
            retire     = 1'b1;
            state_d    = FETCH;
          end else if (is_j || is_jr) begin
            pc_write_o = 1'b1;
            pc_src_o   = is_j ? 2'b10 : 2'b11;
            retire     = 1'b1;
            state_d    = FETCH;
          end else if (is_lw || is_sw) begin
            state_d = MEM;
          end else begin
            state_d = WB;
          end
        end
        MEM: begin
          mem_req_o  = 1'b1;
          addr_sel_o = 1'b1;
          mem_we_o   = is_sw;
          if (mem_ready_i) begin
            retire  = is_sw;
            state_d = is_sw ? FETCH : WB;
          end
        end
        WB: begin
          reg_write_o = 1'b1;
          wb_sel_o    = is_lw;
          retire      = 1'b1;
          state_d     = FETCH;
        end
`ifdef ILLEGAL_TRAP_EN
        HALT: state_d = HALT;
`endif
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      md_cnt_q  <= '0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      if (retire) retired_q <= retired_q + CNT_W'(1);
      if (err_set) err_q <= 1'b1;
    end
  end

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       illegal_q <= 1'b0;
    else if (ill_set) illegal_q <= 1'b1;
  end
  assign illegal_o = illegal_q;
`else
  assign illegal_o = 1'b0;
`endif

  assign state_o   = state_q;
  assign retired_o = retired_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-cycle checks of enables, state and counters.
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  opcode;
  logic        cmp_zero, cmp_gt, md_done, mem_ready;
  logic        mem_req, mem_we, addr_sel, ir_write, pc_write;
  logic [1:0]  pc_src;
  logic        alu_src_imm, alu_start, reg_write, wb_sel;
  logic [2:0]  state;
  logic [15:0] retired;
  logic        err, illegal;

  int n_chk = 0;
  int n_fail = 0;
  int exp_ret = 0;
  int starts = 0;

  multicycle_ctrl #(.CNT_W(16), .MD_TIMEOUT(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .cmp_zero_i(cmp_zero), .cmp_gt_i(cmp_gt),
    .md_done_i(md_done), .mem_ready_i(mem_ready), .mem_req_o(mem_req), .mem_we_o(mem_we),
    .addr_sel_o(addr_sel), .ir_write_o(ir_write), .pc_write_o(pc_write), .pc_src_o(pc_src),
    .alu_src_imm_o(alu_src_imm), .alu_start_o(alu_start), .reg_write_o(reg_write),
    .wb_sel_o(wb_sel), .state_o(state), .retired_o(retired), .err_o(err), .illegal_o(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Zero-wait fetch from FETCH; leaves the bench in DECODE.
  task automatic fetch(input logic [4:0] op);
    opcode    = op;
    mem_ready = 1'b1;
    #1;
    check("fetch_state", 32'(state), 0);
    check("fetch_req", 32'({mem_req, addr_sel, ir_write, pc_write, pc_src}), 32'b101100);
    tick();
    check("decode_state", 32'(state), 1);
  endtask

  initial begin
    rst_n = 1'b0; opcode = 5'h00; cmp_zero = 1'b0; cmp_gt = 1'b0; md_done = 1'b0; mem_ready = 1'b0;
    #3;
    check("rst_state", 32'(state), 0);
    check("rst_retired", 32'(retired), 0);
    check("rst_flags", 32'({err, illegal}), 0);
    mem_ready = 1'b1;
    #1;
    check("rst_enables", 32'({mem_req, ir_write, pc_write, reg_write, alu_start}), 0);
    tick(); tick();
    rst_n = 1'b1;

    // add: F D E W
    fetch(5'h04);
    tick();
    check("add_exec", 32'({state, alu_src_imm, alu_start, reg_write}), {3'd2, 3'b000});
    tick();
    check("add_wb", 32'({state, reg_write, wb_sel, pc_write}), {3'd4, 3'b100});
    check("add_ret_pre", 32'(retired), 0);
    tick();
    exp_ret++;
    check("add_ret", 32'(retired), exp_ret);

    // addi: immediate operand in EXEC
    fetch(5'h0C);
    tick();
    check("addi_imm", 32'(alu_src_imm), 1);
    tick(); tick();
    exp_ret++;

    // lw with memory stalling 3 cycles in MEM
    fetch(5'h12);
    tick();
    check("lw_exec_imm", 32'(alu_src_imm), 1);
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("lw_mem_hold", 32'({state, mem_req, addr_sel, mem_we}), {3'd3, 3'b110});
      tick();
    end
    mem_ready = 1'b1;
    #1;
    check("lw_mem_last", 32'({state, mem_req, addr_sel}), {3'd3, 2'b11});
    tick();
    check("lw_wb", 32'({state, reg_write, wb_sel}), {3'd4, 2'b11});
    tick();
    exp_ret++;
    check("lw_ret", 32'(retired), exp_ret);

    // sw: F D E M, no writeback
    fetch(5'h13);
    tick(); tick();
    check("sw_mem", 32'({mem_req, addr_sel, mem_we, reg_write}), 32'b1110);
    tick();
    exp_ret++;
    check("sw_done", 32'({state, 16'(retired)}), {3'd0, 16'(exp_ret)});

    // beq taken
    fetch(5'h14);
    cmp_zero = 1'b1;
    tick();
    check("beq_taken", 32'({pc_write, pc_src, reg_write}), 32'b1010);
    tick();
    exp_ret++;
    check("beq_ret", 32'({state, 16'(retired)}), {3'd0, 16'(exp_ret)});

    // bne not taken on zero
    fetch(5'h15);
    tick();
    check("bne_not_taken", 32'({pc_write, pc_src}), 0);
    tick();
    exp_ret++;
    check("bne_ret", 32'(retired), exp_ret);
    cmp_zero = 1'b0;

    // bgt taken
    fetch(5'h10);
    cmp_gt = 1'b1;
    tick();
    check("bgt_taken", 32'({pc_write, pc_src}), 32'b101);
    tick();
    exp_ret++;
    cmp_gt = 1'b0;

    // jr and j
    fetch(5'h16);
    tick();
    check("jr_pc", 32'({pc_write, pc_src}), 32'b111);
    tick();
    exp_ret++;
    fetch(5'h17);
    tick();
    check("j_pc", 32'({pc_write, pc_src}), 32'b110);
    tick();
    exp_ret++;
    check("jump_ret", 32'(retired), exp_ret);

    // mult, md_done on the 10th EXEC cycle; md_done during DECODE must be ignored
    fetch(5'h06);
    md_done = 1'b1;
    tick();
    starts = 0;
    for (int k = 1; k <= 10; k++) begin
      md_done = (k == 10);
      #1;
      check("mult_in_exec", 32'(state), 2);
      if (k == 1) check("mult_start_first", 32'(alu_start), 1);
      if (alu_start) starts++;
      tick();
    end
    md_done = 1'b0;
    check("mult_start_count", 32'(starts), 1);
    check("mult_wb", 32'({state, reg_write, wb_sel}), {3'd4, 2'b10});
    tick();
    exp_ret++;
    check("mult_ret", 32'(retired), exp_ret);

    // mult timeout: md_done never arrives
    fetch(5'h06);
    tick();
    for (int k = 1; k <= 32; k++) begin
      check("md_wait_state", 32'(state), 2);
      if (k == 32) check("md_err_before", 32'(err), 0);
      tick();
    end
    check("md_timeout", 32'({state, err, reg_write}), {3'd0, 2'b10});
    check("md_timeout_ret", 32'(retired), exp_ret);

    // reset during MEM with mem_req high
    fetch(5'h12);
    tick();
    mem_ready = 1'b0;
    tick();
    check("rst_mid_req", 32'(mem_req), 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid", 32'({state, mem_req, addr_sel, reg_write, pc_write, err}), 32'd0);
    check("rst_mid_ret", 32'(retired), 0);
    tick();
    rst_n = 1'b1;
    exp_ret = 0;

    // illegal opcode 1F
    fetch(5'h1F);
    tick();
`ifdef ILLEGAL_TRAP_EN
    check("ill_halt", 32'({state, illegal}), {3'd5, 1'b1});
    for (int k = 0; k < 3; k++) begin
      check("halt_quiet", 32'({mem_req, ir_write, pc_write, reg_write}), 0);
      tick();
    end
    check("halt_ret", 32'({state, 16'(retired)}), {3'd5, 16'(exp_ret)});
`else
    exp_ret++;
    check("ill_nop", 32'({state, illegal}), 0);
    check("ill_ret", 32'(retired), exp_ret);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
